// File: rtl/sev_seg_sched_if.sv
// Requester bus for the seven-segment display scheduler.
// Requester A is a priority byte stream with a valid/ready handshake.
// Requester B is a 32-bit background value with a sample strobe and no backpressure.
// The master modport is the requester side; the slave modport is the scheduler side.
interface sev_seg_sched_if;
   logic        a_valid;
   logic [7:0]  a_data;
   logic        a_ready;
   logic        b_valid;
   logic [31:0] b_data;

   modport master (
      output a_valid,
      output a_data,
      output b_valid,
      output b_data,
      input  a_ready
   );

   modport slave (
      input  a_valid,
      input  a_data,
      input  b_valid,
      input  b_data,
      output a_ready
   );
endinterface

// File: rtl/sev_seg_sched.sv
// sev_seg_sched: shares the 8-digit seven-segment display between two requesters.
// An accepted A byte pre-empts the display for HOLD_CYCLES cycles, and each new
// A byte restarts that window. When the window ends, the display shows the last
// B value if one has ever been latched. Otherwise the display goes dark.
// Optional feature: define SEV_SEG_SCHED_LZB_EN to blank leading zeros on the B page.
module sev_seg_sched #(
   parameter int HOLD_CYCLES = 200_000_000
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                freeze,
   sev_seg_sched_if.slave      bus,
   output logic [31:0]         digits,
   output logic [7:0]          blank,
   output logic [1:0]          src_sel
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

   // The encoding doubles as src_sel, so the select output is the state itself.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SHOW_B = 2'b01,
      SHOW_A = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       a_hist_q, a_hist_d;
   logic [2:0]        a_cnt_q, a_cnt_d;
   logic [31:0]       b_lat_q, b_lat_d;
   logic              b_seen_q, b_seen_d;
   logic [CNT_W-1:0]  timer_q, timer_d;
   logic [31:0]       digits_q, digits_d;
   logic [7:0]        blank_q, blank_d;
   logic [1:0]        src_sel_q, src_sel_d;

   logic              a_acc;
   logic              b_acc;

`ifdef SEV_SEG_SCHED_LZB_EN
   logic              lz_run;
`endif

   assign bus.a_ready = ~freeze;
   assign a_acc       = bus.a_valid & ~freeze;
   assign b_acc       = bus.b_valid & ~freeze;

   // Latch the requester data, pick the next page, and run the A hold timer.
   always_comb begin
      a_hist_d = a_hist_q;
      a_cnt_d  = a_cnt_q;
      b_lat_d  = b_lat_q;
      b_seen_d = b_seen_q;
      timer_d  = timer_q;
      state_d  = state_q;

      if (a_acc) begin
         a_hist_d = {a_hist_q[23:0], bus.a_data};
         if (a_cnt_q < 3'd4) begin
            a_cnt_d = a_cnt_q + 3'd1;
         end
      end

      if (b_acc) begin
         b_lat_d  = bus.b_data;
         b_seen_d = 1'b1;
      end

      if (a_acc) begin
         timer_d = CNT_W'(HOLD_CYCLES - 1);
         state_d = SHOW_A;
      end else begin
         case (state_q)
            IDLE: begin
               if (b_acc) begin
                  state_d = SHOW_B;
               end
            end
            SHOW_B: begin
               state_d = SHOW_B;
            end
            SHOW_A: begin
               if (!freeze) begin
                  if (timer_q == '0) begin
                     state_d = (b_seen_q | b_acc) ? SHOW_B : IDLE;
                  end else begin
                     timer_d = timer_q - 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Map the next page onto the digit and blank outputs, so they are registered
   // alongside the state that selects them.
   always_comb begin
      digits_d  = '0;
      blank_d   = 8'hFF;
      src_sel_d = state_d;
`ifdef SEV_SEG_SCHED_LZB_EN
      lz_run    = 1'b1;
`endif
      case (state_d)
         SHOW_A: begin
            digits_d = a_hist_d;
            for (int k = 0; k < 4; k++) begin
               blank_d[2*k +: 2] = (3'(k) >= a_cnt_d) ? 2'b11 : 2'b00;
            end
         end
         SHOW_B: begin
            digits_d = b_lat_d;
            blank_d  = 8'h00;
`ifdef SEV_SEG_SCHED_LZB_EN
            for (int i = 7; i >= 1; i--) begin
               if (lz_run && (b_lat_d[4*i +: 4] == 4'h0)) begin
                  blank_d[i] = 1'b1;
               end else begin
                  lz_run = 1'b0;
               end
            end
`endif
         end
         default: begin
            digits_d = '0;
            blank_d  = 8'hFF;
         end
      endcase
   end

   // State and output registers, with a synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         a_hist_q  <= '0;
         a_cnt_q   <= '0;
         b_lat_q   <= '0;
         b_seen_q  <= 1'b0;
         timer_q   <= '0;
         digits_q  <= '0;
         blank_q   <= 8'hFF;
         src_sel_q <= 2'b00;
      end else begin
         state_q   <= state_d;
         a_hist_q  <= a_hist_d;
         a_cnt_q   <= a_cnt_d;
         b_lat_q   <= b_lat_d;
         b_seen_q  <= b_seen_d;
         timer_q   <= timer_d;
         digits_q  <= digits_d;
         blank_q   <= blank_d;
         src_sel_q <= src_sel_d;
      end
   end

   assign digits  = digits_q;
   assign blank   = blank_q;
   assign src_sel = src_sel_q;

endmodule

// File: tb/tb_sev_seg_sched.sv
// Directed testbench for sev_seg_sched. It uses HOLD_CYCLES = 8 and the default build,
// with leading-zero blanking disabled.
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same point.
module tb_sev_seg_sched;

   logic        clk;
   logic        resetn;
   logic        freeze;
   logic [31:0] digits;
   logic [7:0]  blank;
   logic [1:0]  src_sel;

   int tests_run;
   int tests_failed;

   sev_seg_sched_if bus ();

   sev_seg_sched #(.HOLD_CYCLES(8)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .freeze  (freeze),
      .bus     (bus.slave),
      .digits  (digits),
      .blank   (blank),
      .src_sel (src_sel)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_inputs();
      bus.a_valid = 1'b0;
      bus.a_data  = 8'h00;
      bus.b_valid = 1'b0;
      bus.b_data  = 32'h0;
      freeze      = 1'b0;
   endtask

   task automatic send_a(input logic [7:0] d);
      bus.a_valid = 1'b1;
      bus.a_data  = d;
      tick(1);
      bus.a_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      resetn = 1'b0;
      tick(2);
      resetn = 1'b1;
      tests_run++;
      if ({src_sel, blank, digits} !== {2'b00, 8'hFF, 32'h0}) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got %h want %h", {src_sel, blank, digits}, {2'b00, 8'hFF, 32'h0});
      end
      tick(20);
      tests_run++;
      if ({src_sel, blank, digits} !== {2'b00, 8'hFF, 32'h0}) begin
         tests_failed++;
         $display("[TB] FAIL idle_outputs: got %h want %h", {src_sel, blank, digits}, {2'b00, 8'hFF, 32'h0});
      end
      tests_run++;
      if (bus.a_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL idle_a_ready: got %b want 1", bus.a_ready);
      end
   endtask

   task automatic test_b_page();
      bus.b_valid = 1'b1;
      bus.b_data  = 32'h1234_ABCD;
      tick(1);
      bus.b_valid = 1'b0;
      tests_run++;
      if ({src_sel, blank, digits} !== {2'b01, 8'h00, 32'h1234_ABCD}) begin
         tests_failed++;
         $display("[TB] FAIL b_page: got %h want %h", {src_sel, blank, digits}, {2'b01, 8'h00, 32'h1234_ABCD});
      end
   endtask

   task automatic test_a_preempt();
      send_a(8'h5A);
      tests_run++;
      if ({src_sel, blank, digits} !== {2'b10, 8'hFC, 32'h0000_005A}) begin
         tests_failed++;
         $display("[TB] FAIL a_preempt: got %h want %h", {src_sel, blank, digits}, {2'b10, 8'hFC, 32'h0000_005A});
      end
      tick(7);
      tests_run++;
      if (src_sel !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL a_hold_last_cycle: got %b want 10", src_sel);
      end
      tick(1);
      tests_run++;
      if ({src_sel, blank, digits} !== {2'b01, 8'h00, 32'h1234_ABCD}) begin
         tests_failed++;
         $display("[TB] FAIL a_hold_revert: got %h want %h", {src_sel, blank, digits}, {2'b01, 8'h00, 32'h1234_ABCD});
      end
   endtask

   task automatic test_burst();
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h11;
      tick(1);
      tests_run++;
      if ({blank, digits} !== {8'hF0, 32'h0000_5A11}) begin
         tests_failed++;
         $display("[TB] FAIL burst_two_bytes: got %h want %h", {blank, digits}, {8'hF0, 32'h0000_5A11});
      end
      bus.a_data = 8'h22; tick(1);
      bus.a_data = 8'h33; tick(1);
      bus.a_data = 8'h44; tick(1);
      bus.a_data = 8'h55; tick(1);
      bus.a_valid = 1'b0;
      tests_run++;
      if ({src_sel, blank, digits} !== {2'b10, 8'h00, 32'h2233_4455}) begin
         tests_failed++;
         $display("[TB] FAIL burst_saturate: got %h want %h", {src_sel, blank, digits}, {2'b10, 8'h00, 32'h2233_4455});
      end
      tick(7);
      tests_run++;
      if (src_sel !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL burst_retrigger_hold: got %b want 10", src_sel);
      end
      tick(1);
      tests_run++;
      if ({src_sel, digits} !== {2'b01, 32'h1234_ABCD}) begin
         tests_failed++;
         $display("[TB] FAIL burst_revert: got %h want %h", {src_sel, digits}, {2'b01, 32'h1234_ABCD});
      end
   endtask

   task automatic test_a_only_to_idle();
      resetn = 1'b0;
      tick(1);
      resetn = 1'b1;
      send_a(8'hC3);
      tests_run++;
      if ({src_sel, blank, digits} !== {2'b10, 8'hFC, 32'h0000_00C3}) begin
         tests_failed++;
         $display("[TB] FAIL a_only_show: got %h want %h", {src_sel, blank, digits}, {2'b10, 8'hFC, 32'h0000_00C3});
      end
      tick(8);
      tests_run++;
      if ({src_sel, blank, digits} !== {2'b00, 8'hFF, 32'h0}) begin
         tests_failed++;
         $display("[TB] FAIL a_only_to_idle: got %h want %h", {src_sel, blank, digits}, {2'b00, 8'hFF, 32'h0});
      end
   endtask

   task automatic test_simultaneous();
      resetn = 1'b0;
      tick(1);
      resetn = 1'b1;
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h77;
      bus.b_valid = 1'b1;
      bus.b_data  = 32'h9ABC_DEF0;
      tick(1);
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      tests_run++;
      if ({src_sel, blank, digits} !== {2'b10, 8'hFC, 32'h0000_0077}) begin
         tests_failed++;
         $display("[TB] FAIL simul_a_wins: got %h want %h", {src_sel, blank, digits}, {2'b10, 8'hFC, 32'h0000_0077});
      end
      tick(8);
      tests_run++;
      if ({src_sel, blank, digits} !== {2'b01, 8'h00, 32'h9ABC_DEF0}) begin
         tests_failed++;
         $display("[TB] FAIL simul_b_after: got %h want %h", {src_sel, blank, digits}, {2'b01, 8'h00, 32'h9ABC_DEF0});
      end
   endtask

   task automatic test_freeze_and_reset();
      logic [41:0] snap;
      send_a(8'h3C);
      tick(2);
      snap = {src_sel, blank, digits};
      tests_run++;
      if (snap !== {2'b10, 8'hF0, 32'h0000_773C}) begin
         tests_failed++;
         $display("[TB] FAIL freeze_pre: got %h want %h", snap, {2'b10, 8'hF0, 32'h0000_773C});
      end
      freeze      = 1'b1;
      bus.a_valid = 1'b1;
      bus.a_data  = 8'h99;
      bus.b_valid = 1'b1;
      bus.b_data  = 32'h1111_1111;
      #1;
      tests_run++;
      if (bus.a_ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL freeze_a_ready: got %b want 0", bus.a_ready);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1);
         tests_run++;
         if ({src_sel, blank, digits} !== {2'b10, 8'hF0, 32'h0000_773C}) begin
            tests_failed++;
            $display("[TB] FAIL freeze_hold_%0d: got %h want %h", i, {src_sel, blank, digits}, {2'b10, 8'hF0, 32'h0000_773C});
         end
      end
      idle_inputs();
      tick(5);
      tests_run++;
      if (src_sel !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL freeze_delayed_end: got %b want 10", src_sel);
      end
      tick(1);
      tests_run++;
      if ({src_sel, blank, digits} !== {2'b01, 8'h00, 32'h9ABC_DEF0}) begin
         tests_failed++;
         $display("[TB] FAIL freeze_revert: got %h want %h", {src_sel, blank, digits}, {2'b01, 8'h00, 32'h9ABC_DEF0});
      end
      send_a(8'hE1);
      tick(2);
      resetn = 1'b0;
      tick(1);
      resetn = 1'b1;
      tests_run++;
      if ({src_sel, blank, digits} !== {2'b00, 8'hFF, 32'h0}) begin
         tests_failed++;
         $display("[TB] FAIL midwindow_reset: got %h want %h", {src_sel, blank, digits}, {2'b00, 8'hFF, 32'h0});
      end
      tick(10);
      tests_run++;
      if (src_sel !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL timer_no_resume: got %b want 00", src_sel);
      end
      send_a(8'h42);
      tests_run++;
      if ({blank, digits} !== {8'hFC, 32'h0000_0042}) begin
         tests_failed++;
         $display("[TB] FAIL history_cleared: got %h want %h", {blank, digits}, {8'hFC, 32'h0000_0042});
      end
      tick(8);
      tests_run++;
      if (src_sel !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL b_seen_cleared: got %b want 00", src_sel);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      resetn       = 1'b0;
      idle_inputs();
      @(posedge clk);
      #1;
      test_reset();
      test_b_page();
      test_a_preempt();
      test_burst();
      test_a_only_to_idle();
      test_simultaneous();
      test_freeze_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
